// File: rtl/dac_playback_ctrl_if.sv
// Waveform RAM read-port bundle between the playback controller (master)
// and the DAC-side port of the dual-port waveform memory (slave).
interface dac_playback_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_din,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_din,
    output mem_rdata
  );
endinterface

// File: rtl/dac_playback_ctrl.sv
// DAC playback controller: walks a latched address window of the waveform
// RAM and emits one word every eff_div+1 cycles, once or looping forever.
// The address presented to the RAM is always the word emitted at the next
// strobe, so data is valid well before each tick.
module dac_playback_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  dac_playback_ctrl_if.master   mem,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_LOAD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0]  DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DIV_WIDTH-1:0]  eff_div_q, eff_div_d;
  logic [DIV_WIDTH-1:0]  counter_q, counter_d;
  logic                  loop_q, loop_d;
  logic                  pass_q, pass_d;       // at least one full pass finished
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wrap_q, wrap_d;
  logic                  emit_s;               // a word is emitted at this edge

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_we    = 1'b0;
  assign mem.mem_din   = {DATA_WIDTH{1'b0}};
  assign sample        = sample_q;
  assign sample_valid  = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wrap          = wrap_q;

  // Next-state, fetch address, pacing counter and strobe generation.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    base_d     = base_q;
    last_d     = last_q;
    eff_div_d  = eff_div_q;
    counter_d  = counter_q;
    loop_d     = loop_q;
    pass_d     = pass_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    emit_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          base_d     = base_addr;
          last_d     = last_addr;
          loop_d     = loop_en;
          eff_div_d  = (rate_div == DIV_ZERO) ? DIV_ONE : rate_div;
          mem_addr_d = base_addr;
          pass_d     = 1'b0;
          state_d    = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          emit_s  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (counter_q == DIV_ZERO) begin
          emit_s = 1'b1;
        end else begin
          counter_d = counter_q - DIV_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The RAM output always holds the word at mem_addr_q when we emit.
    if (emit_s) begin
      sample_d  = mem.mem_rdata;
      valid_d   = 1'b1;
      counter_d = eff_div_q;
      wrap_d    = pass_q && (mem_addr_q == base_q);
      if (mem_addr_q == last_q) begin
        if (loop_q) begin
          mem_addr_d = base_q;
          pass_d     = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end else begin
        mem_addr_d = mem_addr_q + ADDR_ONE;
      end
    end else begin
      wrap_d = 1'b0;
    end

    // The final one-shot strobe still counts as busy.
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_addr_q <= {ADDR_WIDTH{1'b0}};
      base_q     <= {ADDR_WIDTH{1'b0}};
      last_q     <= {ADDR_WIDTH{1'b0}};
      eff_div_q  <= DIV_ONE;
      counter_q  <= DIV_ZERO;
      loop_q     <= 1'b0;
      pass_q     <= 1'b0;
      sample_q   <= {DATA_WIDTH{1'b0}};
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      base_q     <= base_d;
      last_q     <= last_d;
      eff_div_q  <= eff_div_d;
      counter_q  <= counter_d;
      loop_q     <= loop_d;
      pass_q     <= pass_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Self-checking bench for dac_playback_ctrl: table of playback windows run
// through a scoreboard of expected strobes, plus hand-written stop and reset
// sequences.
module tb_dac_playback_ctrl;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int VW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] last_addr;
  logic [VW-1:0] rate_div;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          busy;
  logic          done;
  logic          wrap;
  int            cyc;

  dac_playback_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  dac_playback_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_WIDTH(VW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .base_addr    (base_addr),
    .last_addr    (last_addr),
    .rate_div     (rate_div),
    .mem          (mif),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Waveform RAM model: word a holds a*0x10, one cycle read latency.
  always @(posedge clk) mif.mem_rdata <= 32'(mif.mem_addr) << 4;

  typedef struct {
    int          cyc;
    logic [31:0] smp;
    logic        done;
    logic        wrap;
  } exp_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] last;
    logic [VW-1:0] rate;
    logic          lp;
    int            n;         // strobes to observe
    logic [31:0]   last_smp;  // sample held once the run ends
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[5];
  int   checks;
  int   failures;
  int   strobe_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any strobe seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (sample_valid) begin
        strobe_cnt++;
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: got sample 0x%0h at cycle %0d, expected none", sample, cyc);
        end else begin
          e = sbq.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("sample", sample, e.smp);
          chk("done", 32'(done), 32'(e.done));
          chk("wrap", 32'(wrap), 32'(e.wrap));
        end
      end else if (done || wrap) begin
        chk("pulse_without_strobe", {30'd0, done, wrap}, 32'd0);
      end
    end
  endtask

  // Expected strobe sequence for a window started at cycle c0.
  task automatic push_run(input int c0, input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input logic [VW-1:0] r, input logic lp, input int n);
    exp_t e;
    int   len;
    int   eff;
    int   addr;
    len = ((int'(l) - int'(b)) & 2047) + 1;
    eff = (r == 16'd0) ? 1 : int'(r);
    for (int k = 0; k < n; k++) begin
      addr   = (int'(b) + (k % len)) & 2047;
      e.cyc  = c0 + 3 + k * (eff + 1);
      e.smp  = 32'(addr) * 32'h10;
      e.done = !lp && (k == len - 1);
      e.wrap = lp && (k >= len) && ((k % len) == 0);
      sbq.push_back(e);
    end
  endtask

  task automatic wait_q(input int left, input string nm);
    int g;
    g = 0;
    while (sbq.size() > left && g < 400) begin
      tick();
      g++;
    end
    if (sbq.size() > left) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d strobes pending, expected %0d", nm, sbq.size(), left);
      sbq.delete();
    end
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] l,
                           input logic [VW-1:0] r, input logic lp, input int n);
    base_addr = b;
    last_addr = l;
    rate_div  = r;
    loop_en   = lp;
    start     = 1'b1;
    push_run(cyc, b, l, r, lp, n);
    tick();
    start = 1'b0;
    // Config changes while busy must not affect the latched window.
    base_addr = AW'($urandom);
    last_addr = AW'($urandom);
    rate_div  = VW'($urandom_range(0, 7));
    loop_en   = 1'($urandom);
  endtask

  task automatic run_one(input vec_t v);
    strobe_cnt = 0;
    start_run(v.base, v.last, v.rate, v.lp, v.n);
    wait_q(0, "run");
    if (v.lp) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end else begin
      tick();
    end
    chk("busy_after_run", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("held_sample", sample, v.last_smp);
    chk("strobe_count", 32'(strobe_cnt), 32'(v.n));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_mem_addr"}, 32'(mif.mem_addr), 32'd0);
    chk({nm, "_mem_we"}, 32'(mif.mem_we), 32'd0);
    chk({nm, "_mem_din"}, mif.mem_din, 32'd0);
    chk({nm, "_sample"}, sample, 32'd0);
    chk({nm, "_flags"}, {28'd0, sample_valid, busy, done, wrap}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{base: 11'd0,    last: 11'd3,   rate: 16'd1, lp: 1'b0, n: 4, last_smp: 32'h30};
    vecs[1] = '{base: 11'd5,    last: 11'd6,   rate: 16'd3, lp: 1'b1, n: 6, last_smp: 32'h60};
    vecs[2] = '{base: 11'd2046, last: 11'd1,   rate: 16'd0, lp: 1'b0, n: 4, last_smp: 32'h10};
    vecs[3] = '{base: 11'd7,    last: 11'd7,   rate: 16'd2, lp: 1'b1, n: 3, last_smp: 32'h70};
    vecs[4] = '{base: 11'd100,  last: 11'd100, rate: 16'd5, lp: 1'b0, n: 1, last_smp: 32'h640};

    checks = 0; failures = 0; strobe_cnt = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    base_addr = 11'd0; last_addr = 11'd0; rate_div = 16'd0;

    tick();
    tick();
    chk_reset_outputs("in_reset");
    rst = 1'b0;
    tick();
    chk_reset_outputs("after_reset");

    for (int i = 0; i < 5; i++) run_one(vecs[i]);

    // Loop run, stop 2 cycles after the 2nd strobe; starts while busy are dropped.
    strobe_cnt = 0;
    start_run(11'd5, 11'd6, 16'd3, 1'b1, 2);
    wait_q(1, "stop_first");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_q(0, "stop_second");
    tick();
    tick();
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_sample_hold", sample, 32'h60);
    for (int i = 0; i < 10; i++) tick();
    chk("stop_start_dropped", 32'(busy), 32'd0);
    chk("stop_strobe_count", 32'(strobe_cnt), 32'd2);

    // Reset pulse in the middle of a run, then a fresh start.
    strobe_cnt = 0;
    start_run(11'd0, 11'd3, 16'd1, 1'b0, 4);
    wait_q(3, "rst_first");
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    sbq.delete();
    tick();
    rst = 1'b0;
    run_one('{base: 11'd10, last: 11'd10, rate: 16'd0, lp: 1'b0, n: 1, last_smp: 32'hA0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
